// File: rtl/md_pkg.sv
// Shared MDU definitions: MDOp codes, FSM state encodings and op-class helpers.
// Optional madd/maddu/msub/msubu support is enabled with MDU_MADD_EN.
package md_pkg;

    localparam logic [3:0] MD_ELSE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    typedef struct packed {
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
    } md_arith_t;

    // Multiply-latency class; madd-class codes only count when the feature is built in.
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: 64-bit product and quotient/remainder from latched operands.
// Signed division works on magnitudes so -2^31 / -1 stays deterministic.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_arith_t   res_o
);

    logic        mul_sgn, div_sgn;
    logic [63:0] a_ext, b_ext;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic        q_neg;

    assign mul_sgn = (op_i == MD_MULT) || (op_i == MD_MADD) || (op_i == MD_MSUB);
    assign div_sgn = (op_i == MD_DIV);

    // Sign-extended operands give the correct low 64 bits of a two's-complement product.
    assign a_ext = {{32{mul_sgn & a_i[31]}}, a_i};
    assign b_ext = {{32{mul_sgn & b_i[31]}}, b_i};

    assign a_mag = (div_sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign b_mag = (div_sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
    assign q_mag = (b_i == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_i == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign q_neg = div_sgn && (a_i[31] ^ b_i[31]);

    always_comb begin
        res_o.prod = a_ext * b_ext;
        res_o.quo  = q_neg ? (~q_mag + 32'd1) : q_mag;
        res_o.rem  = (div_sgn && a_i[31]) ? (~r_mag + 32'd1) : r_mag;
        res_o.dz   = (b_i == 32'd0);
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide sequencer: owns HI/LO, fixed-latency busy model, MD stall.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (accumulate into HI/LO sampled at issue).
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] md_rd,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   rs_q, rs_d, rt_q, rt_d;
`ifdef MDU_MADD_EN
    logic [63:0]   acc_q, acc_d;
`endif
    logic          issue;
    logic [63:0]   commit_val;
    logic          commit_wr;
    md_arith_t     ar;

    md_arith u_arith (
        .op_i  (op_q),
        .a_i   (rs_q),
        .b_i   (rt_q),
        .res_o (ar)
    );

    assign issue = (state_q == S_IDLE) && md_start && (is_mul_op(md_op) || is_div_op(md_op));

    // Final HI:LO value for the op in flight; divide-by-zero suppresses the write.
    always_comb begin
        commit_val = {hi_q, lo_q};
        commit_wr  = 1'b0;
        case (op_q)
            MD_MULT, MD_MULTU: begin
                commit_val = ar.prod;
                commit_wr  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                commit_val = {ar.rem, ar.quo};
                commit_wr  = !ar.dz;
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                commit_val = acc_q + ar.prod;
                commit_wr  = 1'b1;
            end
            MD_MSUB, MD_MSUBU: begin
                commit_val = acc_q - ar.prod;
                commit_wr  = 1'b1;
            end
`endif
            default: begin
                commit_val = {hi_q, lo_q};
                commit_wr  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
`ifdef MDU_MADD_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = is_div_op(md_op) ? S_DIV : S_MULT;
                    count_d = is_div_op(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    op_d    = md_op;
                    rs_d    = rs_val;
                    rt_d    = rt_val;
`ifdef MDU_MADD_EN
                    acc_d   = {hi_q, lo_q};
`endif
                end else if (md_op == MD_MTHI) begin
                    hi_d = rs_val;
                end else if (md_op == MD_MTLO) begin
                    lo_d = rs_val;
                end
            end
            S_MULT, S_DIV: begin
                // Starts and moves-to while busy are ignored; only the countdown advances.
                if (count_q == CW'(1)) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    if (commit_wr) begin
                        hi_d = commit_val[63:32];
                        lo_d = commit_val[31:0];
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MD_ELSE;
            rs_q    <= '0;
            rt_q    <= '0;
`ifdef MDU_MADD_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign md_stall = busy | md_start;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_rd    = (md_op == MD_MFHI) ? hi_q :
                      (md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus random ops against an arithmetic HI/LO model.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  md_op = MD_ELSE;
    logic        md_start = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [31:0] md_rd, hi, lo;
    logic        busy, md_stall;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    md_unit #(.MULT_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n), .md_op(md_op), .md_start(md_start),
        .rs_val(rs_val), .rt_val(rt_val), .md_rd(md_rd), .busy(busy),
        .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference HI/LO update from the architectural definition of each op.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr, sp;
        logic [63:0] p, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        case (op)
            MD_MULT: begin sp = sa * sb; p = sp; {m_hi, m_lo} = p; end
            MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            MD_DIV: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                p = sq; m_lo = p[31:0];
                p = sr; m_hi = p[31:0];
            end
            MD_DIVU: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            MD_MADD: begin sp = sa * sb; p = sp; {m_hi, m_lo} = acc + p; end
            MD_MADDU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = acc + p; end
            MD_MSUB: begin sp = sa * sb; p = sp; {m_hi, m_lo} = acc - p; end
            MD_MSUBU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = acc - p; end
            default: ;
        endcase
    endtask

    task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] oh;
        chk("idle_before_issue", 64'(busy), 64'd0);
        md_op = op; md_start = 1'b1; rs_val = a; rt_val = b;
        #1;
        chk("stall_on_start", 64'(md_stall), 64'd1);
        oh = m_hi;
        n  = (op == MD_DIV || op == MD_DIVU) ? DIVC : MULC;
        model(op, a, b);
        cyc();
        md_start = 1'b0; md_op = MD_ELSE; rs_val = $urandom; rt_val = $urandom;
        for (int i = 0; i < n; i++) begin
            chk("busy_hold", 64'(busy), 64'd1);
            if (i == n - 1) chk("hi_before_commit", 64'(hi), 64'(oh));
            cyc();
        end
        chk("busy_drop", 64'(busy), 64'd0);
        chk("hi_commit", 64'(hi), 64'(m_hi));
        chk("lo_commit", 64'(lo), 64'(m_lo));
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        md_op = op; md_start = 1'b0; rs_val = v;
        if (op == MD_MTHI) m_hi = v; else m_lo = v;
        cyc();
        md_op = MD_ELSE;
        chk("mt_no_busy", 64'(busy), 64'd0);
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic do_mf();
        md_op = MD_MFHI; #1;
        chk("mfhi_rd", 64'(md_rd), 64'(m_hi));
        md_op = MD_MFLO; #1;
        chk("mflo_rd", 64'(md_rd), 64'(m_lo));
        md_op = MD_ELSE; #1;
        chk("else_rd_zero", 64'(md_rd), 64'd0);
    endtask

    task automatic no_effect(input logic [3:0] op, input logic st);
        md_op = op; md_start = st; rs_val = $urandom; rt_val = $urandom;
        cyc();
        md_op = MD_ELSE; md_start = 1'b0;
        chk("noop_no_busy", 64'(busy), 64'd0);
        chk("noop_hi", 64'(hi), 64'(m_hi));
        chk("noop_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(md_stall), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        cyc();

        do_md(MD_MULT, 32'hFFFFFFFF, 32'd2);
        chk("mult_vec_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_vec_lo", 64'(lo), 64'h0000_0000_FFFF_FFFE);
        do_md(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("multu_vec_hi", 64'(hi), 64'h1);
        do_md(MD_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_vec_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_vec_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        do_md(MD_DIVU, 32'd7, 32'd0);
        chk("divz_hi_kept", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        do_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        do_md(MD_DIV, 32'd7, 32'hFFFFFFFE);

        do_mt(MD_MTHI, 32'h1234);
        do_mf();
        chk("mthi_vec_rd", 64'(hi), 64'h1234);

        for (int v = 13; v < 16; v++) no_effect(4'(v), 1'b1);
`ifdef MDU_MADD_EN
        do_mt(MD_MTHI, 32'd0); do_mt(MD_MTLO, 32'd5);
        do_md(MD_MADD, 32'd3, 32'd4);
        chk("madd_vec_lo", 64'(lo), 64'd17);
        do_mt(MD_MTLO, 32'd0);
        do_md(MD_MSUB, 32'd0, 32'd0);
        do_md(MD_MSUBU, 32'd1, 32'd1);
        chk("msubu_vec_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
`else
        for (int v = 9; v < 13; v++) no_effect(4'(v), 1'b1);
`endif

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1, 2: b = 32'($urandom_range(1, 20));
                3: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            case (op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: do_md(op, a, b);
                MD_MTHI, MD_MTLO: do_mt(op, a);
                MD_MFHI, MD_MFLO: do_mf();
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: do_md(op, a, b);
`endif
                default: no_effect(op, 1'b0);
            endcase
        end

        // Async reset in the middle of a divide discards it and clears HI/LO at once.
        do_mt(MD_MTHI, 32'hAAAA); do_mt(MD_MTLO, 32'h5555);
        md_op = MD_DIV; md_start = 1'b1; rs_val = 32'd100; rt_val = 32'd3;
        cyc();
        md_op = MD_ELSE; md_start = 1'b0;
        cyc(); cyc();
        chk("div_busy_pre_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", 64'(busy), 64'd0);
        chk("midop_rst_hi", 64'(hi), 64'd0);
        chk("midop_rst_lo", 64'(lo), 64'd0);
        m_hi = '0; m_lo = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        do_mf();
        repeat (DIVC) cyc();
        chk("no_late_commit_lo", 64'(lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
